data_memory: RTL

//  Parametrised RISC-V data memory with byte/halfword/word load-store (funct3-encoded).

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_ram_array.sv | 32 +++
 rtl/data_memory.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RISC-V data memory: access-size encoding,
// FSM states and the byte-lane mask used for stores.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  localparam int CNT_W = 4;

  // Any encoding that is not B/H (signed or unsigned) covers the whole word.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      SZ_B, SZ_BU: return 4'b0001 << lane;
      SZ_H, SZ_HU: return lane[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic access_illegal(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      SZ_B, SZ_BU: return 1'b0;
      SZ_H, SZ_HU: return lane[0];
      SZ_W:        return lane != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// 32-bit word RAM split into four byte lanes, each with its own write enable
// and a registered (one edge) read port. Contents are never reset.
module dmem_ram_array #(
  parameter int WORD_W = 8
) (
  input  logic              CLK,
  input  logic [WORD_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** WORD_W;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge CLK) begin
        if (be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        q_reg <= lane_mem[addr];
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/data_memory.sv
// RISC-V data memory: funct3-encoded byte/half/word loads and stores with a
// valid/ready request, configurable access latency and a one-cycle response.
// Optional alignment/encoding check enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              access_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              write_reg;
  logic [2:0]        f3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [31:0]       read_data_reg;

  logic              err_in;
  logic [3:0]        ram_be;
  logic [31:0]       store_lanes;
  logic [31:0]       ram_rdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       resp_data;

`ifdef DMEM_ALIGN_CHECK_EN
  assign err_in = access_illegal(funct3, address[1:0]);
`else
  assign err_in = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      write_reg     <= 1'b0;
      f3_reg        <= 3'b000;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      read_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            write_reg <= MemWrite;
            f3_reg    <= funct3;
            addr_reg  <= address;
            wdata_reg <= write_data;
            err_reg   <= err_in;
            cnt_reg   <= CNT_INIT;
          end
        end
        ST_BUSY: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        ST_RESP: read_data_reg <= resp_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_be     = 4'b0000;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
          // A reset landing on the commit edge must drop the store.
          if (write_reg && !err_reg && !RST) ram_be = lane_mask(f3_reg, addr_reg[1:0]);
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (f3_reg)
      SZ_B, SZ_BU: store_lanes = {4{wdata_reg[7:0]}};
      SZ_H, SZ_HU: store_lanes = {2{wdata_reg[15:0]}};
      default:     store_lanes = wdata_reg;
    endcase
  end

  dmem_ram_array #(
    .WORD_W(ADDR_W - 2)
  ) u_ram (
    .CLK  (CLK),
    .addr (addr_reg[ADDR_W-1:2]),
    .be   (ram_be),
    .wdata(store_lanes),
    .rdata(ram_rdata)
  );

  assign byte_sel = ram_rdata[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = ram_rdata[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_reg)
      SZ_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_ext = {24'h000000, byte_sel};
      SZ_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_ext = {16'h0000, half_sel};
      default: load_ext = ram_rdata;
    endcase
  end

  // Stores leave the previous load result visible; errors force zero.
  assign resp_data  = err_reg ? 32'h0 : (write_reg ? read_data_reg : load_ext);
  assign read_data  = (state_reg == ST_RESP) ? resp_data : read_data_reg;
  assign access_err = (state_reg == ST_RESP) && err_reg;

endmodule
